// File: rtl/seq_detect_prog_if.sv
// Serial pattern-detector bus: data/control inputs toward the detector
// and match/status outputs back to the host.
interface seq_detect_prog_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap_en;
    logic             cnt_clr;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             searching;

    modport master (
        output din, din_valid, pat_load, pat_in, overlap_en, cnt_clr,
        input  match, match_cnt, searching
    );

    modport slave (
        input  din, din_valid, pat_load, pat_in, overlap_en, cnt_clr,
        output match, match_cnt, searching
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with overlap control, valid
// qualification and a saturating match counter.
module seq_detect_prog #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_prog_if.slave bus
);
    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] SEARCH = 1'b1;

    localparam int               FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_LAST = FW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [PAT_W-1:0] pattern_reg, pattern_next;
    logic [PAT_W-1:0] hist_reg, hist_next;
    logic [FW-1:0]    fill_reg, fill_next;
    logic [0:0]       state_reg, state_next;
    logic             match_reg, match_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             accept;
    logic             hit;
    logic [PAT_W-1:0] cand;

    assign accept = bus.din_valid & ~bus.pat_load;
    assign cand   = {hist_reg[PAT_W-2:0], bus.din};
    // In FILL the candidate is only complete when this bit is the PAT_W-th one.
    assign hit    = accept && (cand == pattern_reg)
                    && ((state_reg == SEARCH) || (fill_reg == FILL_LAST));

    always_comb begin
        pattern_next = pattern_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        state_next   = state_reg;
        match_next   = hit;
        cnt_next     = cnt_reg;

        if (bus.pat_load) begin
            pattern_next = bus.pat_in;
            hist_next    = '0;
            fill_next    = '0;
            state_next   = FILL;
        end else if (accept) begin
            if (hit && !bus.overlap_en) begin
                hist_next  = '0;
                fill_next  = '0;
                state_next = FILL;
            end else begin
                hist_next = cand;
                if (state_reg == FILL) begin
                    fill_next = fill_reg + FW'(1);
                    if (fill_reg == FILL_LAST) begin
                        state_next = SEARCH;
                    end
                end
            end
        end

        // A clear coinciding with a match leaves the new match counted.
        if (bus.cnt_clr) begin
            cnt_next = hit ? CNT_W'(1) : '0;
        end else if (hit && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_reg <= PAT_RST;
            hist_reg    <= '0;
            fill_reg    <= '0;
            state_reg   <= FILL;
            match_reg   <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            pattern_reg <= pattern_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            state_reg   <= state_next;
            match_reg   <= match_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign bus.match     = match_reg;
    assign bus.match_cnt = cnt_reg;
    assign bus.searching = (state_reg == SEARCH);
endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed table-driven bench for seq_detect_prog, plus hand-written
// async-reset and counter-saturation sequences.
module tb_seq_detect_prog;
    logic clk;
    logic rst;

    int n_vec;
    int n_err;

    typedef struct {
        logic       din;
        logic       dv;
        logic       ld;
        logic [3:0] pat;
        logic       ov;
        logic       clr;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_srch;
    } vec_t;

    vec_t tbl[$];

    seq_detect_prog_if #(.PAT_W(4), .CNT_W(8)) ifa ();
    seq_detect_prog_if #(.PAT_W(4), .CNT_W(2)) ifb ();

    seq_detect_prog #(.PAT_W(4), .PAT_RST(4'b1001), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    seq_detect_prog #(.PAT_W(4), .PAT_RST(4'b1111), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic din, input logic dv, input logic ld,
                                input logic [3:0] pat, input logic ov, input logic clr,
                                input logic em, input logic [7:0] ec, input logic es);
        vec_t v;
        v.din = din; v.dv = dv; v.ld = ld; v.pat = pat; v.ov = ov; v.clr = clr;
        v.e_match = em; v.e_cnt = ec; v.e_srch = es;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        ifa.din        = v.din;
        ifa.din_valid  = v.dv;
        ifa.pat_load   = v.ld;
        ifa.pat_in     = v.pat;
        ifa.overlap_en = v.ov;
        ifa.cnt_clr    = v.clr;
        @(posedge clk);
        #1;
        chk({tag, ".match"}, int'(ifa.match), int'(v.e_match));
        chk({tag, ".cnt"}, int'(ifa.match_cnt), int'(v.e_cnt));
        chk({tag, ".srch"}, int'(ifa.searching), int'(v.e_srch));
        $display("%s din=%0d dv=%0d ld=%0d match=%0d cnt=%0d srch=%0d",
                 tag, v.din, v.dv, v.ld, ifa.match, ifa.match_cnt, ifa.searching);
    endtask

    initial begin
        logic [1:0] exp_b_cnt[8];
        logic       exp_b_match[8];
        n_vec = 0;
        n_err = 0;

        // Overlap on, default 1001: pulses after bits 4 and 7.
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 1, 2, 1));
        // Reload restarts the search; count is kept.
        tbl.push_back(mk(1, 1, 1, 4'b1001, 0, 0, 0, 2, 0));
        // Overlap off: one pulse, searching returns after bit 8.
        tbl.push_back(mk(1, 1, 0, 4'h0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 0, 0, 1, 3, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 3, 1));
        // Stalls of 3 invalid cycles between bits (din=1 during stalls).
        tbl.push_back(mk(1, 1, 1, 4'b1001, 1, 0, 0, 3, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 3, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 4'h0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 3, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 4'h0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 3, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 0, 4'h0, 1, 0, 0, 3, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 1, 4, 1));
        tbl.push_back(mk(1, 0, 0, 4'h0, 1, 0, 0, 4, 1));
        // Load 1101 with a valid bit on the load edge (discarded).
        tbl.push_back(mk(1, 1, 1, 4'b1101, 1, 0, 0, 4, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 4, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 1, 5, 1));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 5, 1));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 5, 1));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 1, 6, 1));
        // cnt_clr with pat_load -> 0; cnt_clr with a match -> 1.
        tbl.push_back(mk(1, 1, 1, 4'b1101, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 1, 1, 1, 1));
        // Partial stream before the asynchronous reset.
        tbl.push_back(mk(1, 1, 1, 4'b1101, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 4'h0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 4'h0, 1, 0, 0, 1, 0));

        rst = 1'b1;
        ifa.din = 0; ifa.din_valid = 0; ifa.pat_load = 0; ifa.pat_in = '0;
        ifa.overlap_en = 0; ifa.cnt_clr = 0;
        ifb.din = 0; ifb.din_valid = 0; ifb.pat_load = 0; ifb.pat_in = '0;
        ifb.overlap_en = 0; ifb.cnt_clr = 0;
        #12;
        chk("rst.match", int'(ifa.match), 0);
        chk("rst.cnt", int'(ifa.match_cnt), 0);
        chk("rst.srch", int'(ifa.searching), 0);
        $display("reset: match=%0d cnt=%0d srch=%0d", ifa.match, ifa.match_cnt, ifa.searching);
        #1 rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Asynchronous reset between edges: outputs clear without a clock.
        #2 rst = 1'b1;
        #1;
        chk("arst.match", int'(ifa.match), 0);
        chk("arst.cnt", int'(ifa.match_cnt), 0);
        chk("arst.srch", int'(ifa.searching), 0);
        $display("async reset: match=%0d cnt=%0d srch=%0d", ifa.match, ifa.match_cnt, ifa.searching);
        #3 rst = 1'b0;
        // Pattern back to 1001 and history empty: a lone 1 must not match.
        apply(mk(1, 1, 0, 4'h0, 1, 0, 0, 0, 0), "post_rst0");
        apply(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 0), "post_rst1");
        apply(mk(0, 1, 0, 4'h0, 1, 0, 0, 0, 0), "post_rst2");
        apply(mk(1, 1, 0, 4'h0, 1, 0, 1, 1, 1), "post_rst3");

        // CNT_W=2, pattern 1111, overlap: eight 1s, clear on the 8th.
        exp_b_match = '{0, 0, 0, 1, 1, 1, 1, 1};
        exp_b_cnt   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
        for (int k = 0; k < 8; k++) begin
            ifb.din        = 1'b1;
            ifb.din_valid  = 1'b1;
            ifb.overlap_en = 1'b1;
            ifb.cnt_clr    = (k == 7);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.match", k), int'(ifb.match), int'(exp_b_match[k]));
            chk($sformatf("sat%0d.cnt", k), int'(ifb.match_cnt), int'(exp_b_cnt[k]));
            $display("sat%0d din=1 match=%0d cnt=%0d srch=%0d",
                     k, ifb.match, ifb.match_cnt, ifb.searching);
        end
        ifb.din_valid = 1'b0;
        ifb.cnt_clr   = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
